sprite_blitter: RTL and testbench

- Upstream writer of the 1024-byte monochrome framebuffer RAM: executes the CHIP-8 DXYN draw.
- Fetches N sprite bytes from main memory and read-modify-writes (XOR) them into the framebuffer through its read/write ports.
- Reports pixel collision for VF.
- Framebuffer geometry: 128x64 pixels, 16 bytes per row, byte address = row*16 + column_byte, MSB = leftmost pixel.

---
 rtl/sprite_blitter_if.sv | 31 +++
 rtl/sprite_blitter.sv | 139 +++++++++++++
 tb/tb_sprite_blitter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: draw request/status plus main-memory and framebuffer ports.
// master = requester side (also returns RAM read data), slave = blitter.
interface sprite_blitter_if #(
  parameter int MEM_ADDR_W = 12
);
  logic                  start;
  logic [6:0]            x;
  logic [5:0]            y;
  logic [3:0]            n;
  logic [MEM_ADDR_W-1:0] sprite_addr;
  logic                  busy;
  logic                  done;
  logic                  collision;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [7:0]            mem_q;
  logic [9:0]            fb_read_address;
  logic [7:0]            fb_q;
  logic [9:0]            fb_write_address;
  logic [7:0]            fb_d;
  logic                  fb_we;

  modport master (
    output start, x, y, n, sprite_addr, mem_q, fb_q,
    input  busy, done, collision, mem_addr, fb_read_address, fb_write_address, fb_d, fb_we
  );

  modport slave (
    input  start, x, y, n, sprite_addr, mem_q, fb_q,
    output busy, done, collision, mem_addr, fb_read_address, fb_write_address, fb_d, fb_we
  );
endinterface

// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN sprite blitter: XOR-draws N sprite rows into a 128x64 byte-wide framebuffer.
// Optional SPRITE_CLIP_EN: clip at the bottom/right screen edges instead of wrapping.
module sprite_blitter #(
  parameter int MEM_ADDR_W = 12
) (
  input logic             clk,
  input logic             reset,
  sprite_blitter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_SPR, RD_FB0, WR_FB0, RD_FB1, WR_FB1, NEXT, DONE} state_t;

  state_t                state;
  logic [6:0]            x_r;
  logic [5:0]            y_r;
  logic [3:0]            n_r, row, row_nx;
  logic [MEM_ADDR_W-1:0] sa_r, mem_addr_r;
  logic [7:0]            spr, mask;
  logic [15:0]           sh;
  logic [2:0]            s;
  logic [3:0]            xb;
  logic [5:0]            yr;
  logic [9:0]            left, right, fb_ra, fb_wa;
  logic                  busy_r, done_r, coll_r, we_r, hit, do_right, skip_row;

  assign s      = x_r[2:0];
  assign xb     = x_r[6:3];
  assign yr     = y_r + {2'b00, row};
  assign left   = {yr, xb};
  assign right  = {yr, xb + 4'd1};
  assign row_nx = row + 4'd1;

  // Upper byte is the left-byte mask (spr>>s), lower byte the spill into the right byte.
  assign sh   = {spr, 8'h00} >> s;
  assign mask = (state == WR_FB1) ? sh[7:0] : sh[15:8];
  assign hit  = |(bus.fb_q & mask);

`ifdef SPRITE_CLIP_EN
  logic [6:0] y_nx;
  assign y_nx     = {1'b0, y_r} + {3'b000, row_nx};
  assign do_right = (s != 3'd0) && (xb != 4'hF);
  assign skip_row = y_nx[6];
`else
  assign do_right = (s != 3'd0);
  assign skip_row = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      coll_r     <= 1'b0;
      we_r       <= 1'b0;
      mem_addr_r <= '0;
      fb_ra      <= '0;
      fb_wa      <= '0;
      x_r        <= '0;
      y_r        <= '0;
      n_r        <= '0;
      sa_r       <= '0;
      row        <= '0;
      spr        <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          x_r    <= bus.x;
          y_r    <= bus.y;
          n_r    <= bus.n;
          sa_r   <= bus.sprite_addr;
          row    <= '0;
          coll_r <= 1'b0;
          busy_r <= 1'b1;
          if (bus.n == 4'd0) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            state      <= RD_SPR;
            mem_addr_r <= bus.sprite_addr;
          end
        end
        RD_SPR: begin
          fb_ra <= left;
          state <= RD_FB0;
        end
        // Read port moves off the byte being written so read and write never collide.
        RD_FB0: begin
          spr   <= bus.mem_q;
          we_r  <= 1'b1;
          fb_wa <= left;
          fb_ra <= right;
          state <= WR_FB0;
        end
        WR_FB0: begin
          coll_r <= coll_r | hit;
          we_r   <= 1'b0;
          state  <= do_right ? RD_FB1 : NEXT;
        end
        RD_FB1: begin
          we_r  <= 1'b1;
          fb_wa <= right;
          fb_ra <= left;
          state <= WR_FB1;
        end
        WR_FB1: begin
          coll_r <= coll_r | hit;
          we_r   <= 1'b0;
          state  <= NEXT;
        end
        NEXT: begin
          row <= row_nx;
          if (row_nx == n_r) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else if (skip_row) begin
            state <= NEXT;
          end else begin
            mem_addr_r <= sa_r + MEM_ADDR_W'(row_nx);
            state      <= RD_SPR;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.collision        = coll_r;
  assign bus.mem_addr         = mem_addr_r;
  assign bus.fb_read_address  = fb_ra;
  assign bus.fb_write_address = fb_wa;
  assign bus.fb_we            = we_r;
  assign bus.fb_d             = we_r ? (bus.fb_q ^ mask) : 8'h00;
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: pixel-level DXYN model, write scoreboard, directed draws.
module tb_sprite_blitter;
  localparam int AW = 12;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_blitter_if #(.MEM_ADDR_W(AW)) bus ();
  sprite_blitter #(.MEM_ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] fb_ram [1024] = '{default: 8'h00};
  logic [7:0] main_mem [4096];

  always @(posedge clk) begin
    bus.fb_q  <= fb_ram[bus.fb_read_address];
    bus.mem_q <= main_mem[bus.mem_addr];
    if (bus.fb_we) fb_ram[bus.fb_write_address] <= bus.fb_d;
  end

  typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
  wr_t  exp_q[$];
  logic pix [64][128];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fb_byte(input int r, input int cb);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = pix[r][cb*8+i];
    return b;
  endfunction

  // Pixel-level DXYN: toggle pixels, derive expected byte writes, collision and latency.
  task automatic model_draw(input int x, input int y, input int n, input int sa,
                            output logic coll, output int lat);
    coll = 1'b0;
    lat  = 1;
    for (int r = 0; r < n; r++) begin
      logic [7:0] b = main_mem[(sa + r) % 4096];
      int py = (y + r) % 64;
      int cb = x / 8;
      bit rgt = (x % 8) != 0;
`ifdef SPRITE_CLIP_EN
      if (y + r > 63) begin lat += 1; continue; end
      if (cb == 15) rgt = 0;
`endif
      for (int i = 0; i < 8; i++) begin
        int px = (x + i) % 128;
`ifdef SPRITE_CLIP_EN
        if (x + i > 127) continue;
`endif
        if (b[7-i]) begin
          if (pix[py][px]) coll = 1'b1;
          pix[py][px] = ~pix[py][px];
        end
      end
      exp_q.push_back({10'(py*16 + cb), fb_byte(py, cb)});
      if (rgt) exp_q.push_back({10'(py*16 + (cb+1)%16), fb_byte(py, (cb+1)%16)});
      lat += rgt ? 6 : 4;
    end
  endtask

  task automatic draw(input int x, input int y, input int n, input int sa, input bit poke,
                      output logic mcoll);
    int lat, cyc;
    model_draw(x, y, n, sa, mcoll, lat);
    bus.x = 7'(x); bus.y = 6'(y); bus.n = 4'(n); bus.sprite_addr = AW'(sa);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    chk("busy_after_start", int'(bus.busy), 1);
    while (!bus.done && cyc < 300) begin
      if (poke && cyc == 3) begin
        bus.x = 7'd0; bus.y = 6'd0; bus.n = 4'd1; bus.sprite_addr = AW'(12'h100);
        bus.start = 1'b1;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("latency", cyc, lat);
    chk("collision", int'(bus.collision), int'(mcoll));
    chk("writes_outstanding", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("idle_after_done", int'({bus.busy, bus.done}), 0);
    chk("collision_held", int'(bus.collision), int'(mcoll));
  endtask

  initial begin
    logic mc;
    int   lat, nb;
    for (int r = 0; r < 64; r++) for (int c = 0; c < 128; c++) pix[r][c] = 1'b0;
    for (int a = 0; a < 4096; a++) main_mem[a] = 8'h00;
    main_mem['h100] = 8'hF0;
    main_mem['h110] = 8'hFF;
    main_mem['h120] = 8'hFF; main_mem['h121] = 8'hFF;
    main_mem['h130] = 8'hE0;
    main_mem['h140] = 8'h3C; main_mem['h141] = 8'h42; main_mem['h142] = 8'h81; main_mem['h143] = 8'hFF;
    main_mem['h150] = 8'hAA; main_mem['h151] = 8'h55; main_mem['h152] = 8'hFF;
    main_mem['h153] = 8'h0F; main_mem['h154] = 8'hF0;
    main_mem['hFFE] = 8'hC3; main_mem['hFFF] = 8'h81; main_mem['h000] = 8'h3C;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.n = '0; bus.sprite_addr = '0;

    // Write scoreboard: every fb_we cycle must match the next modelled write.
    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (bus.fb_we) begin
          chk("rw_same_addr", int'(bus.fb_read_address == bus.fb_write_address), 0);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: addr %0d data 0x%02h, none expected",
                     bus.fb_write_address, bus.fb_d);
          end else begin
            e = exp_q.pop_front();
            chk("fb_write", int'({bus.fb_write_address, bus.fb_d}), int'(e));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", int'({bus.busy, bus.done, bus.collision, bus.fb_we}), 0);
    chk("rst_addrs", int'({bus.mem_addr, bus.fb_read_address}), 0);
    chk("rst_wr", int'({bus.fb_write_address, bus.fb_d}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    draw(0, 0, 1, 'h100, 0, mc);
    chk("lit_coll_first", int'(bus.collision), 0);
    chk("lit_fb0_f0", int'(fb_ram[0]), 'hF0);
    draw(0, 0, 1, 'h100, 0, mc);
    chk("lit_coll_repeat", int'(bus.collision), 1);
    chk("lit_fb0_00", int'(fb_ram[0]), 'h00);

    draw(5, 2, 1, 'h110, 0, mc);
    chk("lit_fb32", int'(fb_ram[32]), 'h07);
    chk("lit_fb33", int'(fb_ram[33]), 'hF8);

    draw(125, 63, 2, 'h120, 0, mc);
    chk("lit_fb1023", int'(fb_ram[1023]), 'h07);
`ifdef SPRITE_CLIP_EN
    chk("lit_fb1008", int'(fb_ram[1008]), 'h00);
    chk("lit_fb15", int'(fb_ram[15]), 'h00);
    chk("lit_fb0", int'(fb_ram[0]), 'h00);
`else
    chk("lit_fb1008", int'(fb_ram[1008]), 'hF8);
    chk("lit_fb15", int'(fb_ram[15]), 'h07);
    chk("lit_fb0", int'(fb_ram[0]), 'hF8);
`endif

    draw(3, 4, 0, 'h100, 0, mc);
    chk("lit_n0_coll", int'(bus.collision), 0);

    draw(60, 30, 4, 'h140, 1, mc);
    draw(64, 61, 5, 'h150, 0, mc);
    draw(7, 20, 3, 'hFFE, 0, mc);
    draw(60, 30, 4, 'h140, 0, mc);
    chk("lit_redraw_coll", int'(bus.collision), 1);

    // Reset during WR_FB1 of a colliding redraw.
    draw(5, 10, 1, 'h130, 0, mc);
    chk("lit_fb160_set", int'(fb_ram[160]), 'h07);
    model_draw(5, 10, 1, 'h130, mc, lat);
    bus.x = 7'd5; bus.y = 6'd10; bus.n = 4'd1; bus.sprite_addr = AW'(12'h130);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("we_in_wr_fb1", int'(bus.fb_we), 1);
    chk("coll_before_reset", int'(bus.collision), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", int'(bus.fb_we), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_coll", int'(bus.collision), 0);
    chk("rst_mid_pending", exp_q.size(), 1);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("lit_fb160_cleared", int'(fb_ram[160]), 'h00);
    chk("lit_fb161", int'(fb_ram[161]), 'h00);
    @(posedge clk); #1;
    draw(5, 10, 1, 'h130, 0, mc);
    chk("lit_after_rst_coll", int'(bus.collision), 0);
    chk("lit_fb160_again", int'(fb_ram[160]), 'h07);

    nb = 0;
    for (int a = 0; a < 1024; a++) if (fb_ram[a] != fb_byte(a / 16, a % 16)) nb++;
    chk("fb_final_bad_bytes", nb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
